// File: rtl/inbuf_reader_pkg.sv
// Shared constants for the input-buffer read side.
// Default widths and derived depth/level sizes.
package inbuf_reader_pkg;

  localparam int ADDR_BITS_DEF = 10;
  localparam int DATA_BITS_DEF = 16;
  localparam int DEPTH_DEF     = 1 << ADDR_BITS_DEF;

  function automatic int depth_of(input int ab);
    return 1 << ab;
  endfunction

  function automatic int lvl_w(input int ab);
    return ab + 1;
  endfunction

endpackage

// File: rtl/inbuf_skid2.sv
// Two-entry fall-through output FIFO.
// Head plus skid register; empty FIFO passes push data straight out.
module inbuf_skid2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         r,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic [1:0]   cnt
);

  logic [W-1:0] head;
  logic [W-1:0] skid;

  assign valid = (cnt != 2'd0) || push;
  assign dout  = (cnt == 2'd0 && push) ? din : head;

  // Storage and occupancy update for push/pop combinations.
  always_ff @(posedge clk) begin
    if (r) begin
      head <= '0;
      skid <= '0;
      cnt  <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= din;
          else if (cnt == 2'd1) skid <= din;
          if (cnt != 2'd2) cnt <= cnt + 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd2) head <= skid;
          if (cnt != 2'd0) cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            head <= din;
          end else if (cnt == 2'd2) begin
            head <= skid;
            skid <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inbuf_reader.sv
// Read-side controller for the input sample buffer.
// Tracks unread level, issues RAM reads, streams samples out.
module inbuf_reader
  import inbuf_reader_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 r,
  input  logic                 wr_en,
  output logic                 ram_rd,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [DATA_BITS-1:0] ram_dout,
  output logic                 m_valid,
  output logic [DATA_BITS-1:0] m_data,
  input  logic                 m_ready,
  output logic [ADDR_BITS:0]   level,
  output logic                 co,
  output logic                 ovf
);

  localparam int LW = lvl_w(ADDR_BITS);
  localparam logic [LW-1:0] FULL = LW'(depth_of(ADDR_BITS));
  localparam logic [ADDR_BITS-1:0] LAST = '1;

  logic       inflight;
  logic       pop;
  logic [1:0] cnt;
  logic [2:0] occ;

  assign pop    = m_valid && m_ready;
  assign occ    = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};
  assign ram_rd = (level != '0) && (occ < 3'd2);
  assign co     = ram_rd && (rd_addr == LAST);

  // Read address, in-flight tracking, level and sticky overflow.
  always_ff @(posedge clk) begin
    if (r) begin
      rd_addr  <= '0;
      inflight <= 1'b0;
      level    <= '0;
      ovf      <= 1'b0;
    end else begin
      inflight <= ram_rd;
      if (ram_rd) rd_addr <= rd_addr + ADDR_BITS'(1);
      if (wr_en && !ram_rd) begin
        if (level == FULL) ovf <= 1'b1;
        else level <= level + LW'(1);
      end else if (!wr_en && ram_rd) begin
        level <= level - LW'(1);
      end
    end
  end

  inbuf_skid2 #(
    .W(DATA_BITS)
  ) u_skid (
    .clk  (clk),
    .r    (r),
    .push (inflight),
    .din  (ram_dout),
    .pop  (pop),
    .valid(m_valid),
    .dout (m_data),
    .cnt  (cnt)
  );

endmodule

// File: tb/tb_inbuf_reader.sv
// Directed self-checking bench for inbuf_reader.
// Small 4-entry buffer with a behavioural RAM and writer.
module tb_inbuf_reader;

  logic        clk = 1'b0;
  logic        r = 1'b1;
  logic        wr_en = 1'b0;
  logic        ram_rd;
  logic [1:0]  rd_addr;
  logic [15:0] ram_dout = '0;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready = 1'b0;
  logic [2:0]  level;
  logic        co;
  logic        ovf;

  logic [15:0] mem [4];
  logic [1:0]  wp = '0;
  int          errs = 0;
  int          nchk = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_rd) ram_dout <= mem[rd_addr];

  inbuf_reader #(
    .ADDR_BITS(2),
    .DATA_BITS(16)
  ) dut (
    .clk     (clk),
    .r       (r),
    .wr_en   (wr_en),
    .ram_rd  (ram_rd),
    .rd_addr (rd_addr),
    .ram_dout(ram_dout),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .level   (level),
    .co      (co),
    .ovf     (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    r = 1'b1;
    wr_en = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    r = 1'b0;
    wp = '0;
  endtask

  task automatic wr(input logic [15:0] d);
    wr_en = 1'b1;
    mem[wp] = d;
    wp = wp + 2'd1;
  endtask

  initial begin
    int lv[7] = '{1, 1, 1, 2, 3, 4, 4};
    int nrd;
    int got;
    for (int i = 0; i < 4; i++) mem[i] = '0;

    // reset state
    do_reset();
    #1;
    chk("rst_level", level, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_rd", ram_rd, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_co", co, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_data", m_data, 0);

    // single sample latency
    @(negedge clk);
    m_ready = 1'b1;
    wr(16'hA5A5);
    #1;
    chk("t1_rd0", ram_rd, 0);
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    chk("t1_rd1", ram_rd, 1);
    chk("t1_addr", rd_addr, 0);
    chk("t1_lvl1", level, 1);
    @(negedge clk);
    #1;
    chk("t1_valid", m_valid, 1);
    chk("t1_data", m_data, 16'hA5A5);
    chk("t1_lvl2", level, 0);
    @(negedge clk);
    #1;
    chk("t1_drain", m_valid, 0);

    // burst of 4, address wrap
    do_reset();
    m_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c < 4) wr(16'h1000 + 16'(c));
      else wr_en = 1'b0;
      #1;
      chk("t2_rd", ram_rd, (c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) chk("t2_addr", rd_addr, c - 1);
      chk("t2_co", co, (c == 4));
      chk("t2_valid", m_valid, (c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) chk("t2_data", m_data, 16'h1000 + c - 2);
    end
    chk("t2_wrap", rd_addr, 0);

    // backpressure
    do_reset();
    nrd = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 3) wr(16'h3000 + 16'(c));
      else wr_en = 1'b0;
      #1;
      nrd += int'(ram_rd);
      if (c >= 3) begin
        chk("t3_stall", ram_rd, 0);
        chk("t3_level", level, 1);
        chk("t3_valid", m_valid, 1);
        chk("t3_hold", m_data, 16'h3000);
      end
    end
    chk("t3_nrd", nrd, 2);
    got = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      if (m_valid) begin
        chk("t3_order", m_data, 16'h3000 + got);
        got++;
      end
    end
    chk("t3_count", got, 3);

    // overflow
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 7) wr(16'h4000 + 16'(c));
      else wr_en = 1'b0;
      #1;
      if (c >= 1) chk("t4_level", level, lv[c-1]);
      chk("t4_ovf", ovf, (c == 7));
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("t4_sticky", ovf, 1);
      chk("t4_full", level, 4);
    end
    do_reset();
    #1;
    chk("t4_clr", ovf, 0);
    chk("t4_lvl0", level, 0);

    // simultaneous write and read at level 2
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 4) wr(16'h5000 + 16'(c));
      else wr_en = 1'b0;
    end
    #1;
    chk("t5_lvl", level, 2);
    chk("t5_idle", ram_rd, 0);
    @(negedge clk);
    m_ready = 1'b1;
    wr(16'h5004);
    #1;
    chk("t5_rd", ram_rd, 1);
    @(negedge clk);
    wr_en = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("t5_same", level, 2);

    // reset mid-stream
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      wr(16'h6000 + 16'(c));
    end
    @(negedge clk);
    m_ready = 1'b1;
    wr(16'h6005);
    #1;
    chk("t6_rd", ram_rd, 1);
    @(negedge clk);
    r = 1'b1;
    wr_en = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("t6_pre_lvl", level, 3);
    chk("t6_pre_val", m_valid, 1);
    @(negedge clk);
    r = 1'b0;
    wp = '0;
    #1;
    chk("t6_valid", m_valid, 0);
    chk("t6_level", level, 0);
    chk("t6_addr", rd_addr, 0);
    chk("t6_rd0", ram_rd, 0);
    chk("t6_data", m_data, 0);
    @(negedge clk);
    #1;
    chk("t6_late", m_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
